// File: rtl/attribute_collector_if.sv
// attribute_collector_if: parser-side inputs, record output handshake and error status of the attribute collector.
interface attribute_collector_if #(
  parameter int TYPE_W   = 4,
  parameter int VAL_W    = 16,
  parameter int NUM_ATTR = 11
);
  logic                      element_start;
  logic                      element_end;
  logic                      attr_done;
  logic [TYPE_W-1:0]         attr_type;
  logic [VAL_W-1:0]          attr_value;
  logic                      parser_enable;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_ATTR*VAL_W-1:0] out_attrs;
  logic [NUM_ATTR-1:0]       out_present;
  logic [7:0]                err_count;
  modport master (
    output element_start, element_end, attr_done, attr_type, attr_value, out_ready,
    input  parser_enable, out_valid, out_attrs, out_present, err_count
  );
  modport slave (
    input  element_start, element_end, attr_done, attr_type, attr_value, out_ready,
    output parser_enable, out_valid, out_attrs, out_present, err_count
  );
endinterface

// File: rtl/attribute_collector.sv
// attribute_collector: gathers parsed attributes of one element into per-type slots and emits them as a record.
module attribute_collector #(
  parameter int TYPE_W   = 4,
  parameter int VAL_W    = 16,
  parameter int NUM_ATTR = 11
) (
  input logic                  clock,
  input logic                  reset,
  attribute_collector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, REARM, EMIT} state_t;
  state_t state, next;
  logic [VAL_W-1:0]    slot [NUM_ATTR];
  logic [NUM_ATTR-1:0] present;
  logic [7:0]          errs;
  logic                open, clear, capture, bad;
  assign open    = state == COLLECT || state == REARM;
  assign clear   = bus.element_start && (state == IDLE || open);
  // a restart in the same cycle as attr_done discards that attribute
  assign capture = state == COLLECT && bus.attr_done && !bus.element_start;
  assign bad     = 32'(bus.attr_type) >= NUM_ATTR;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.element_start ? COLLECT : IDLE;
      COLLECT: next = bus.element_start ? COLLECT : bus.element_end ? EMIT : bus.attr_done ? REARM : COLLECT;
      REARM:   next = bus.element_start ? COLLECT : bus.element_end ? EMIT : COLLECT;
      EMIT:    next = bus.out_ready ? IDLE : EMIT;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.parser_enable = state == COLLECT;
    bus.out_valid     = state == EMIT;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_ATTR; i++) slot[i] <= '0;
      present <= '0;
      errs    <= '0;
    end else begin
      for (int i = 0; i < NUM_ATTR; i++)
        if (clear) slot[i] <= '0;
        else if (capture && !bad && 32'(bus.attr_type) == i) slot[i] <= bus.attr_value;
      present <= clear ? '0 : (capture && !bad) ? present | (NUM_ATTR'(1) << bus.attr_type) : present;
      if (capture && bad && errs != 8'hFF) errs <= errs + 8'd1;
    end
  for (genvar k = 0; k < NUM_ATTR; k++) begin : g_out
    assign bus.out_attrs[k*VAL_W +: VAL_W] = slot[k];
  end
  assign bus.out_present = present;
  assign bus.err_count   = errs;
endmodule

// File: tb/tb_attribute_collector.sv
// tb_attribute_collector: directed scenarios with hand-computed expected records.
module tb_attribute_collector;
  localparam int AW = 11 * 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total  = 0;
  logic [AW-1:0] exp_attrs;
  attribute_collector_if bus ();
  attribute_collector dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic start_elem;
    bus.element_start = 1'b1;
    tick();
    bus.element_start = 1'b0;
  endtask
  task automatic send_attr(input logic [3:0] t, input logic [15:0] v);
    bus.attr_done  = 1'b1;
    bus.attr_type  = t;
    bus.attr_value = v;
    tick();
    bus.attr_done = 1'b0;
    tick();
  endtask
  task automatic end_elem;
    bus.element_end = 1'b1;
    tick();
    bus.element_end = 1'b0;
  endtask
  task automatic consume;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset;
    tick();
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL reset_pe got %b exp 0", bus.parser_enable); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_attrs !== '0) $display("FAIL reset_attrs got %h exp 0", bus.out_attrs); else passed++;
    total++; if (bus.out_present !== 11'h000) $display("FAIL reset_present got %h exp 000", bus.out_present); else passed++;
    total++; if (bus.err_count !== 8'd0) $display("FAIL reset_err got %0d exp 0", bus.err_count); else passed++;
    reset = 1'b0;
    tick();
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL post_reset_idle_pe got %b exp 0", bus.parser_enable); else passed++;
  endtask
  task automatic test_basic;
    start_elem();
    total++; if (bus.parser_enable !== 1'b1) $display("FAIL basic_collect_pe got %b exp 1", bus.parser_enable); else passed++;
    send_attr(4'd2, 16'd120);
    send_attr(4'd3, 16'd40);
    end_elem();
    exp_attrs = '0;
    exp_attrs[2*16 +: 16] = 16'd120;
    exp_attrs[3*16 +: 16] = 16'd40;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_attrs !== exp_attrs) $display("FAIL basic_attrs got %h exp %h", bus.out_attrs, exp_attrs); else passed++;
    total++; if (bus.out_present !== 11'h00C) $display("FAIL basic_present got %h exp 00c", bus.out_present); else passed++;
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL basic_emit_pe got %b exp 0", bus.parser_enable); else passed++;
    consume();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_consumed got %b exp 0", bus.out_valid); else passed++;
  endtask
  task automatic test_duplicate;
    start_elem();
    bus.attr_done  = 1'b1;
    bus.attr_type  = 4'd0;
    bus.attr_value = 16'd5;
    tick();
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL dup_rearm_pe got %b exp 0", bus.parser_enable); else passed++;
    bus.attr_value = 16'd9;
    tick();
    total++; if (bus.parser_enable !== 1'b1) $display("FAIL dup_recollect_pe got %b exp 1", bus.parser_enable); else passed++;
    total++; if (bus.out_attrs[15:0] !== 16'd5) $display("FAIL dup_rearm_ignored got %0d exp 5", bus.out_attrs[15:0]); else passed++;
    tick();
    bus.attr_done = 1'b0;
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL dup_rearm2_pe got %b exp 0", bus.parser_enable); else passed++;
    tick();
    end_elem();
    exp_attrs = '0;
    exp_attrs[15:0] = 16'd9;
    total++; if (bus.out_attrs !== exp_attrs) $display("FAIL dup_attrs got %h exp %h", bus.out_attrs, exp_attrs); else passed++;
    total++; if (bus.out_present !== 11'h001) $display("FAIL dup_present got %h exp 001", bus.out_present); else passed++;
    consume();
  endtask
  task automatic test_errors;
    start_elem();
    send_attr(4'd12, 16'd7);
    total++; if (bus.err_count !== 8'd1) $display("FAIL err_one got %0d exp 1", bus.err_count); else passed++;
    total++; if (bus.out_present !== 11'h000) $display("FAIL err_present got %h exp 000", bus.out_present); else passed++;
    total++; if (bus.out_attrs !== '0) $display("FAIL err_attrs got %h exp 0", bus.out_attrs); else passed++;
    for (int i = 0; i < 255; i++) send_attr(4'd12, 16'd7);
    total++; if (bus.err_count !== 8'd255) $display("FAIL err_saturate got %0d exp 255", bus.err_count); else passed++;
    send_attr(4'd15, 16'd1);
    total++; if (bus.err_count !== 8'd255) $display("FAIL err_hold got %0d exp 255", bus.err_count); else passed++;
    end_elem();
    consume();
  endtask
  task automatic test_backpressure;
    start_elem();
    send_attr(4'd5, 16'h1234);
    end_elem();
    exp_attrs = '0;
    exp_attrs[5*16 +: 16] = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      bus.element_start = (i == 1);
      bus.element_end   = (i == 3);
      tick();
      total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid_%0d got %b exp 1", i, bus.out_valid); else passed++;
      total++; if (bus.out_attrs !== exp_attrs) $display("FAIL bp_attrs_%0d got %h exp %h", i, bus.out_attrs, exp_attrs); else passed++;
    end
    bus.element_start = 1'b0;
    bus.element_end   = 1'b0;
    total++; if (bus.out_present !== 11'h020) $display("FAIL bp_present got %h exp 020", bus.out_present); else passed++;
    consume();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_done_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL bp_idle_pe got %b exp 0", bus.parser_enable); else passed++;
  endtask
  task automatic test_same_cycle;
    start_elem();
    bus.attr_done   = 1'b1;
    bus.attr_type   = 4'd6;
    bus.attr_value  = 16'h00FF;
    bus.element_end = 1'b1;
    tick();
    bus.attr_done   = 1'b0;
    bus.element_end = 1'b0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL same_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_attrs[6*16 +: 16] !== 16'h00FF) $display("FAIL same_slot6 got %h exp 00ff", bus.out_attrs[6*16 +: 16]); else passed++;
    total++; if (bus.out_present !== 11'h040) $display("FAIL same_present got %h exp 040", bus.out_present); else passed++;
    consume();
  endtask
  task automatic test_abort;
    start_elem();
    send_attr(4'd1, 16'h0011);
    bus.element_start = 1'b1;
    bus.element_end   = 1'b1;
    tick();
    bus.element_start = 1'b0;
    bus.element_end   = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.parser_enable !== 1'b1) $display("FAIL abort_pe got %b exp 1", bus.parser_enable); else passed++;
    total++; if (bus.out_present !== 11'h000) $display("FAIL abort_present got %h exp 000", bus.out_present); else passed++;
    send_attr(4'd4, 16'h0044);
    end_elem();
    exp_attrs = '0;
    exp_attrs[4*16 +: 16] = 16'h0044;
    total++; if (bus.out_attrs !== exp_attrs) $display("FAIL abort_attrs got %h exp %h", bus.out_attrs, exp_attrs); else passed++;
    total++; if (bus.out_present !== 11'h010) $display("FAIL abort_rec_present got %h exp 010", bus.out_present); else passed++;
    consume();
  endtask
  task automatic test_reset_mid;
    start_elem();
    send_attr(4'd2, 16'h00AB);
    total++; if (bus.out_present !== 11'h004) $display("FAIL mid_before got %h exp 004", bus.out_present); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.out_present !== 11'h000) $display("FAIL mid_async_present got %h exp 000", bus.out_present); else passed++;
    total++; if (bus.out_attrs !== '0) $display("FAIL mid_async_attrs got %h exp 0", bus.out_attrs); else passed++;
    total++; if (bus.err_count !== 8'd0) $display("FAIL mid_async_err got %0d exp 0", bus.err_count); else passed++;
    total++; if (bus.parser_enable !== 1'b0) $display("FAIL mid_async_pe got %b exp 0", bus.parser_enable); else passed++;
    bus.element_end = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.element_end = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_no_record got %b exp 0", bus.out_valid); else passed++;
    start_elem();
    total++; if (bus.out_present !== 11'h000) $display("FAIL mid_clean got %h exp 000", bus.out_present); else passed++;
    send_attr(4'd3, 16'h0003);
    end_elem();
    exp_attrs = '0;
    exp_attrs[3*16 +: 16] = 16'h0003;
    total++; if (bus.out_attrs !== exp_attrs) $display("FAIL mid_rec_attrs got %h exp %h", bus.out_attrs, exp_attrs); else passed++;
    total++; if (bus.out_present !== 11'h008) $display("FAIL mid_rec_present got %h exp 008", bus.out_present); else passed++;
    consume();
  endtask
  initial begin
    bus.element_start = 1'b0;
    bus.element_end   = 1'b0;
    bus.attr_done     = 1'b0;
    bus.attr_type     = '0;
    bus.attr_value    = '0;
    bus.out_ready     = 1'b0;
    test_reset();
    test_basic();
    test_duplicate();
    test_errors();
    test_backpressure();
    test_same_cycle();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
